store_buffer: RTL

- Sits directly downstream of the store-data aligner in the MEM stage.
- Accepts aligned store words, byte strobes and addresses, and queues them in a small FIFO.
- Drains the FIFO to the data-cache SRAM-like port: one write outstanding at a time, using a req/addr_ok/data_ok handshake.
- Flags loads that read a word with a pending store so the pipeline can stall. Also reports empty, for sync/exception drain.

---
 rtl/store_buffer_pkg.sv | 33 +++
 rtl/store_buffer_if.sv | 23 ++
 rtl/store_buffer_fifo.sv | 72 +++++++
 rtl/store_buffer.sv | 91 +++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the MEM-stage store buffer: cache access sizes,
// drain FSM encoding, the queued entry layout and the strobe-to-size decode.
package store_buffer_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } sb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } sb_entry_t;

  // Patterns that are not legal store strobes fall back to a word access.
  function automatic logic [1:0] strb_to_size(input logic [3:0] strb);
    logic [1:0] size;
    case (strb)
      4'b1111:                            size = SIZE_WORD;
      4'b0011, 4'b1100:                   size = SIZE_HALF;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
      default:                            size = SIZE_WORD;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Data-cache write port of the store buffer (SRAM-like req/addr_ok/data_ok).
//   master : store buffer side, drives the request and payload
//   slave  : cache side, returns addr_ok / data_ok
interface store_buffer_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok
  );
endinterface

// File: rtl/store_buffer_fifo.sv
// sb_fifo: circular store queue with valid bits, pointers and occupancy count,
// plus a per-entry word-address match vector used for load hazard detection.
//   clk/resetn  : clock, async active-low reset
//   push/entry  : enqueue at the write pointer (ignored when full)
//   pop         : dequeue the head (ignored when empty)
//   ld_word     : load word address; match[i] = valid[i] and same word
//   head/count/full/empty : queue status
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  sb_entry_t        entry,
  input  logic             pop,
  input  logic [31:2]      ld_word,
  output sb_entry_t        head,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic [DEPTH-1:0] match
);

  sb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rptr];

  // Payload storage needs no reset: valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= entry;
  end

  // Push and pop never target the same slot: that would need count to be
  // both 0 (pop blocked) and DEPTH (push blocked).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        valid[wptr] <= 1'b1;
        wptr        <= wptr + PTR_W'(1);
      end
      if (do_pop) begin
        valid[rptr] <= 1'b0;
        rptr        <= rptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign match[i] = valid[i] && (mem[i].addr[31:2] == ld_word);
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: queues aligned stores from the MEM stage and drains them in
// order to the data cache, one write outstanding at a time.
//   clk, resetn            : clock, async active-low reset
//   st_valid/addr/wdata/wstrb, st_ready : store input (st_ready = not full)
//   ld_addr, ld_hit        : load word hazard against any queued store
//   sb_empty               : nothing queued and drain FSM idle
//   dbus (master)          : cache write port
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  st_valid,
  input  logic [31:0]           st_addr,
  input  logic [31:0]           st_wdata,
  input  logic [3:0]            st_wstrb,
  output logic                  st_ready,
  input  logic [31:0]           ld_addr,
  output logic                  ld_hit,
  output logic                  sb_empty,
  store_buffer_if.master        dbus
);

  sb_state_e        state_q, state_d;
  sb_entry_t        st_entry, head;
  logic [PTR_W:0]   count;
  logic             full, empty, push, pop, req;
  logic [DEPTH-1:0] match;
  logic             unused_ld_lo;

  assign st_entry     = '{addr: st_addr, wdata: st_wdata, wstrb: st_wstrb};
  assign st_ready     = ~full;
  assign push         = st_valid & st_ready;
  assign unused_ld_lo = ^ld_addr[1:0];

  sb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (push),
    .entry   (st_entry),
    .pop     (pop),
    .ld_word (ld_addr[31:2]),
    .head    (head),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .match   (match)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // A push in the same cycle counts toward "work pending" so that a store
  // into an empty buffer is requested on the very next cycle.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!empty || push) state_d = REQ;
      REQ: begin
        req = 1'b1;
        if (dbus.data_addr_ok) state_d = WAIT;
      end
      WAIT: begin
        if (dbus.data_data_ok) begin
          pop     = 1'b1;
          state_d = (count > (PTR_W+1)'(1) || push) ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Payload is driven only alongside the request; zero otherwise.
  assign dbus.data_req   = req;
  assign dbus.data_wr    = req;
  assign dbus.data_size  = req ? strb_to_size(head.wstrb) : SIZE_BYTE;
  assign dbus.data_addr  = req ? head.addr  : 32'd0;
  assign dbus.data_wstrb = req ? head.wstrb : 4'd0;
  assign dbus.data_wdata = req ? head.wdata : 32'd0;

  assign ld_hit   = |match;
  assign sb_empty = empty && (state_q == IDLE);

endmodule
